// File: rtl/wb_cmd_master_pkg.sv
// Shared definitions for the Wishbone command master.
//   state_t          : FSM state encoding (also exported on the debug port)
//   cmd_entry_t      : one queued command {we, adr, dat, sel}
//   *_W / ENTRY_W    : command field widths and total FIFO entry width
//   TIMEOUT_DEFAULT  : default number of bus cycles to wait for an ack
package wb_cmd_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int WE_W    = 1;
  localparam int ADR_W   = 32;
  localparam int DAT_W   = 32;
  localparam int SEL_W   = 4;
  localparam int ENTRY_W = WE_W + ADR_W + DAT_W + SEL_W;

  localparam int TIMEOUT_DEFAULT = 200;

  typedef struct packed {
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic [SEL_W-1:0] sel;
  } cmd_entry_t;

endpackage

// File: rtl/wb_cmd_fifo.sv
// Registered command FIFO with no fall-through: a word written on an edge
// becomes visible at rd_data only after that edge.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (flushes contents)
//   wr_en, wr_data    : push request/data, ignored when full
//   full              : no room for another word
//   rd_en             : pop the head, ignored when empty
//   rd_data, empty    : current head word, FIFO holds nothing
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module wb_cmd_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 69
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_ok;
  logic             rd_ok;

  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: only the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone command master: queues commands in a small FIFO and issues them
// one at a time as single Wishbone classic cycles, returning one response
// per command (read data or zero, plus an error flag on timeout).
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        : command handshake; cmd_we/adr/dat/sel payload
//   rsp_valid/rsp_ready        : response handshake; rsp_dat/rsp_err payload
//   wbm_*_o, wbm_dat_i/ack_i   : Wishbone initiator interface
//   busy                       : commands queued or a transaction in flight
//   dbg_state                  : current FSM state, for observation only
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// producer holds valid and payload stable until it does. rsp_valid/data
// hold until accepted.
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int TSIZE   = 8,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [31:0] wbm_adr_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy,
  output state_t      dbg_state
);

  state_t             state_q, state_d;
  logic [TSIZE-1:0]   tmo_q;
  logic               tmo_hit;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  cmd_entry_t         push_entry;
  cmd_entry_t         head;
  logic               bus_q;

  assign push_entry = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};

  wb_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cmd_valid),
    .wr_data (push_entry),
    .full    (fifo_full),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);
  assign wbm_cyc_o = bus_q;
  assign wbm_stb_o = bus_q;
  assign dbg_state = state_q;

  // Counter reaches TIMEOUT-1 on the TIMEOUT-th bus cycle without an ack.
  assign tmo_hit = (tmo_q == TSIZE'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        if (wbm_ack_i || tmo_hit) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tmo_q     <= '0;
      bus_q     <= 1'b0;
      wbm_adr_o <= '0;
      wbm_we_o  <= 1'b0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            bus_q     <= 1'b1;
            tmo_q     <= '0;
            wbm_adr_o <= head.adr;
            wbm_we_o  <= head.we;
            wbm_dat_o <= head.dat;
            wbm_sel_o <= head.sel;
          end
        end
        ST_BUS: begin
          // Ack wins over a coincident timeout.
          if (wbm_ack_i) begin
            bus_q     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_dat   <= wbm_we_o ? '0 : wbm_dat_i;
          end else if (tmo_hit) begin
            bus_q     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_dat   <= '0;
          end else begin
            tmo_q <= tmo_q + TSIZE'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
